// File: rtl/nmi_arb_pkg.sv
// Shared types and constants for the NMI round-robin arbiter.
package nmi_arb_pkg;

  localparam int unsigned NMI_AW = 32;
  localparam int unsigned NMI_DW = 32;
  localparam int unsigned NMI_SW = 4;

  localparam logic [NMI_DW-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_ERR  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/nmi_if.sv
// picorv32-style native memory interface: valid/addr/wdata/wstrb out, rdata/ready back.
interface nmi_if;
  import nmi_arb_pkg::*;

  logic              valid;
  logic [NMI_AW-1:0] addr;
  logic [NMI_DW-1:0] wdata;
  logic [NMI_SW-1:0] wstrb;
  logic [NMI_DW-1:0] rdata;
  logic              ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/nmi_rr_sel.sv
// Combinational round-robin picker: first set request after rr_ptr_i, wrapping.
module nmi_rr_sel #(
  parameter  int unsigned NUM_MASTER = 2,
  localparam int unsigned IW         = $clog2(NUM_MASTER)
) (
  input  logic [NUM_MASTER-1:0] req_i,
  input  logic [IW-1:0]         rr_ptr_i,
  output logic [NUM_MASTER-1:0] gnt_o,
  output logic [IW-1:0]         idx_o
);

  logic        w_found;
  int unsigned w_k;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int unsigned i = 1; i <= NUM_MASTER; i++) begin
      w_k = (32'(rr_ptr_i) + i) % NUM_MASTER;
      if (!w_found && req_i[IW'(w_k)]) begin
        w_found            = 1'b1;
        idx_o              = IW'(w_k);
        gnt_o[IW'(w_k)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nmi_arbiter.sv
// Round-robin arbiter sharing one NMI slave port among NUM_MASTER requesters,
// with a per-transaction watchdog that completes hung accesses with an error word.
module nmi_arbiter
  import nmi_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTER     = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  parameter  logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT,
  localparam int unsigned IW             = $clog2(NUM_MASTER),
  localparam int unsigned CW             = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_MASTER-1:0]        m_valid_i,
  input  logic [NUM_MASTER-1:0][31:0]  m_addr_i,
  input  logic [NUM_MASTER-1:0][31:0]  m_wdata_i,
  input  logic [NUM_MASTER-1:0][3:0]   m_wstrb_i,
  output logic [NUM_MASTER-1:0][31:0]  m_rdata_o,
  output logic [NUM_MASTER-1:0]        m_ready_o,
  nmi_if.master                        nmi,
  output logic [NUM_MASTER-1:0]        grant_o,
  output logic                         timeout_o,
  output logic [IW-1:0]                timeout_id_o,
  input  logic                         timeout_clr_i
);

  arb_state_e            r_state, w_state_n;
  logic [NUM_MASTER-1:0] r_grant, w_grant_n;
  logic [IW-1:0]         r_ptr, w_ptr_n;
  logic [CW-1:0]         r_cnt, w_cnt_n;
  logic                  r_timeout, w_timeout_n;
  logic [IW-1:0]         r_timeout_id, w_timeout_id_n;
  logic [NUM_MASTER-1:0] w_sel_gnt;
  logic [IW-1:0]         w_sel_idx;

  nmi_rr_sel #(.NUM_MASTER(NUM_MASTER)) u_sel (
    .req_i    (m_valid_i),
    .rr_ptr_i (r_ptr),
    .gnt_o    (w_sel_gnt),
    .idx_o    (w_sel_idx)
  );

  // r_ptr doubles as the owner index while a grant is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_ptr        <= IW'(NUM_MASTER - 1);
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
      r_timeout_id <= '0;
    end else begin
      r_state      <= w_state_n;
      r_grant      <= w_grant_n;
      r_ptr        <= w_ptr_n;
      r_cnt        <= w_cnt_n;
      r_timeout    <= w_timeout_n;
      r_timeout_id <= w_timeout_id_n;
    end
  end

  // Next state, watchdog, sticky flag and the combinational bus mux.
  always_comb begin
    w_state_n      = r_state;
    w_grant_n      = r_grant;
    w_ptr_n        = r_ptr;
    w_cnt_n        = r_cnt;
    w_timeout_n    = r_timeout & ~timeout_clr_i;
    w_timeout_id_n = r_timeout_id;
    nmi.valid      = 1'b0;
    nmi.addr       = '0;
    nmi.wdata      = '0;
    nmi.wstrb      = '0;
    m_ready_o      = '0;
    m_rdata_o      = '0;
    unique case (r_state)
      ARB_IDLE: begin
        if (|m_valid_i) begin
          w_state_n = ARB_BUSY;
          w_grant_n = w_sel_gnt;
          w_ptr_n   = w_sel_idx;
          w_cnt_n   = '0;
        end
      end
      ARB_BUSY: begin
        nmi.valid          = m_valid_i[r_ptr];
        nmi.addr           = m_addr_i[r_ptr];
        nmi.wdata          = m_wdata_i[r_ptr];
        nmi.wstrb          = m_wstrb_i[r_ptr];
        m_ready_o[r_ptr]   = nmi.ready;
        m_rdata_o[r_ptr]   = nmi.rdata;
        if (nmi.ready || !m_valid_i[r_ptr]) begin
          w_state_n = ARB_IDLE;
          w_grant_n = '0;
        end else if (TIMEOUT_CYCLES != 0 && r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_state_n = ARB_ERR;
        end else if (r_cnt != '1) begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      ARB_ERR: begin
        m_ready_o[r_ptr] = 1'b1;
        m_rdata_o[r_ptr] = ERR_RDATA;
        w_timeout_n      = 1'b1;
        if (!r_timeout) w_timeout_id_n = r_ptr;
        w_state_n        = ARB_IDLE;
        w_grant_n        = '0;
      end
      default: begin
        w_state_n = ARB_IDLE;
        w_grant_n = '0;
      end
    endcase
  end

  assign grant_o      = r_grant;
  assign timeout_o    = r_timeout;
  assign timeout_id_o = r_timeout_id;

endmodule
